// File: rtl/psram_responder.sv
// Octal-bus PSRAM responder: decodes command/address/data bursts
// sampled from the PSRAM pins and serves them from an internal byte RAM.
module psram_responder #(
    parameter int ADDR_W = 12,
    parameter int LAT    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_psram_csn,
    input  logic       i_psram_sclk,
    input  logic [7:0] i_psram_din,
    output logic [7:0] o_psram_dout,
    output logic       o_psram_oe,
    output logic [2:0] o_state,
    output logic       o_busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DUMMY  = 3'd3;
    localparam logic [2:0] S_RD     = 3'd4;
    localparam logic [2:0] S_WR     = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] LAT_LAST = 4'(LAT - 1);

    logic              r_csn_s1, r_csn_s2;
    logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic [7:0]        r_din_s1, r_din_s2;
    logic [1:0]        r_warm;
    logic              r_armed;
    logic [2:0]        r_state;
    logic [1:0]        r_cnt;
    logic [3:0]        r_dcnt;
    logic              r_wr;
    logic              r_first;
    logic [23:0]       r_addr;
    logic [7:0]        r_nxt;
    logic [7:0]        r_dout;
    logic              r_oe;
    logic [7:0]        r_mem [DEPTH];

    logic              w_rise;
    logic              w_fall;
    logic              w_wen;
    logic [ADDR_W-1:0] w_idx;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_ridx;
    logic              w_unused;

    assign w_rise   = r_sclk_s2 & ~r_sclk_d;
    assign w_fall   = ~r_sclk_s2 & r_sclk_d;
    assign w_idx    = r_addr[ADDR_W-1:0];
    assign w_inc    = w_idx + ADDR_W'(1);
    assign w_ridx   = r_first ? w_idx : w_inc;
    assign w_wen    = (r_state == S_WR) & w_rise & ~r_csn_s2;
    // High address bits are carried but only alias into the RAM.
    assign w_unused = ^r_addr;

    // Pin synchronizers, sclk edge tap, and a warm-up gate so a CSn
    // already low when reset releases is not mistaken for a new frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_csn_s1  <= 1'b1;
            r_csn_s2  <= 1'b1;
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_din_s1  <= 8'h00;
            r_din_s2  <= 8'h00;
            r_warm    <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_csn_s1  <= i_psram_csn;
            r_csn_s2  <= r_csn_s1;
            r_sclk_s1 <= i_psram_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_din_s1  <= i_psram_din;
            r_din_s2  <= r_din_s1;
            r_warm    <= {r_warm[0], 1'b1};
            r_armed   <= r_armed | (r_warm[1] & r_csn_s2);
        end
    end

    // Transaction FSM; CSn high overrides every state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_dcnt  <= 4'd0;
            r_wr    <= 1'b0;
            r_first <= 1'b1;
            r_addr  <= 24'h0;
            r_dout  <= 8'h00;
            r_oe    <= 1'b0;
        end else if (r_csn_s2) begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_armed) begin
                        r_state <= S_CMD;
                        r_cnt   <= 2'd0;
                    end
                end
                S_CMD: begin
                    if (w_rise) begin
                        r_cnt <= 2'd0;
                        if (r_din_s2 == 8'h02) begin
                            r_wr    <= 1'b1;
                            r_state <= S_ADDR;
                        end else if (r_din_s2 == 8'h0B) begin
                            r_wr    <= 1'b0;
                            r_state <= S_ADDR;
                        end else begin
                            r_state <= S_IGNORE;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rise) begin
                        r_addr <= {r_addr[15:0], r_din_s2};
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd2) begin
                            if (r_wr) begin
                                r_state <= S_WR;
                            end else if (LAT == 0) begin
                                r_state <= S_RD;
                                r_first <= 1'b1;
                            end else begin
                                r_state <= S_DUMMY;
                                r_dcnt  <= 4'd0;
                            end
                        end
                    end
                end
                S_DUMMY: begin
                    if (w_rise) begin
                        r_dcnt <= r_dcnt + 4'd1;
                        if (r_dcnt == LAT_LAST) begin
                            r_state <= S_RD;
                            r_first <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (w_fall) begin
                        r_oe    <= 1'b1;
                        r_dout  <= r_nxt;
                        r_first <= 1'b0;
                        if (!r_first) begin
                            r_addr[ADDR_W-1:0] <= w_inc;
                        end
                    end
                end
                S_WR: begin
                    if (w_rise) begin
                        r_addr[ADDR_W-1:0] <= w_inc;
                    end
                end
                S_IGNORE: begin
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte RAM with write port and a one-byte-ahead registered read.
    always_ff @(posedge i_clk) begin
        if (w_wen) begin
            r_mem[w_idx] <= r_din_s2;
        end
        r_nxt <= r_mem[w_ridx];
    end

    assign o_psram_dout = r_dout;
    assign o_psram_oe   = r_oe;
    assign o_state      = r_state;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_psram_responder.sv
// Bench for psram_responder: directed bus sequences plus random bursts
// checked against a flat byte-array model of the PSRAM contents.
module tb_psram_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       csn;
    logic       sclk;
    logic [7:0] din;
    logic [7:0] dout4, dout0;
    logic       oe4, oe0;
    logic [2:0] st4, st0;
    logic       busy4, busy0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model [4096];
    logic [7:0] wbuf [16];
    logic [23:0] qa [$];
    int          qn [$];

    psram_responder #(.ADDR_W(12), .LAT(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_psram_csn(csn),
        .i_psram_sclk(sclk), .i_psram_din(din),
        .o_psram_dout(dout4), .o_psram_oe(oe4),
        .o_state(st4), .o_busy(busy4)
    );

    psram_responder #(.ADDR_W(12), .LAT(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_psram_csn(csn),
        .i_psram_sclk(sclk), .i_psram_din(din),
        .o_psram_dout(dout0), .o_psram_oe(oe0),
        .o_state(st0), .o_busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int midx(input logic [23:0] a, input int i);
        return (int'(a[11:0]) + i) % 4096;
    endfunction

    task automatic pulse(input logic [7:0] b);
        din = b;
        #40 sclk = 1'b1;
        #40 sclk = 1'b0;
    endtask

    task automatic start();
        csn = 1'b0;
        #20 chk("busy_before", busy4, 0);
        #10 chk("busy_after", busy4, 1);
        #10;
    endtask

    task automatic stop();
        #40 csn = 1'b1;
        #20 chk("busy_hold", busy4, 1);
        #10 chk("busy_drop", busy4, 0);
        chk("idle_state", st4, 0);
        chk("idle_oe", oe4, 0);
        chk("idle_oe0", oe0, 0);
        #20;
    endtask

    task automatic wr_txn(input logic [23:0] a, input int n);
        start();
        chk("wr_cmd_state", st4, 1);
        pulse(8'h02);
        chk("wr_addr_state", st4, 2);
        pulse(a[23:16]);
        pulse(a[15:8]);
        pulse(a[7:0]);
        chk("wr_data_state", st4, 5);
        chk("wr_oe", oe4, 0);
        for (int i = 0; i < n; i++) begin
            pulse(wbuf[i]);
            model[midx(a, i)] = wbuf[i];
        end
        chk("wr_oe_end", oe4, 0);
        stop();
    endtask

    task automatic rd_txn(input logic [23:0] a, input int n, input bit lat0);
        logic [7:0] d;
        logic       o;
        logic [2:0] s;
        start();
        pulse(8'h0B);
        pulse(a[23:16]);
        pulse(a[15:8]);
        chk("rd_addr_oe", lat0 ? oe0 : oe4, 0);
        pulse(a[7:0]);
        if (!lat0) begin
            chk("rd_dummy_state", st4, 3);
            for (int i = 0; i < 4; i++) begin
                chk("rd_dummy_oe", oe4, 0);
                pulse(8'h00);
            end
        end
        for (int i = 0; i < n; i++) begin
            #40;
            d = lat0 ? dout0 : dout4;
            o = lat0 ? oe0 : oe4;
            s = lat0 ? st0 : st4;
            chk("rd_byte", d, model[midx(a, i)]);
            chk("rd_oe", o, 1);
            chk("rd_state", s, 4);
            sclk = 1'b1;
            #40 sclk = 1'b0;
        end
        stop();
    endtask

    initial begin
        logic [23:0] ra;
        int          rn;
        int          k;
        rst  = 1'b1;
        csn  = 1'b1;
        sclk = 1'b0;
        din  = 8'h00;
        #20;
        chk("rst_dout", dout4, 0);
        chk("rst_oe", oe4, 0);
        chk("rst_state", st4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_oe0", oe0, 0);
        #20 rst = 1'b0;
        #40;

        // round trip
        wbuf[0] = 8'hA5;
        wbuf[1] = 8'h3C;
        wr_txn(24'h000010, 2);
        rd_txn(24'h000010, 2, 1'b0);

        // wrap-around and aliasing
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        wr_txn(24'h000FFF, 2);
        rd_txn(24'h000000, 1, 1'b0);
        rd_txn(24'h000FFF, 2, 1'b0);
        rd_txn(24'hABC010, 2, 1'b0);

        // abort after two address bytes
        start();
        pulse(8'h02);
        pulse(8'h00);
        pulse(8'h00);
        stop();
        rd_txn(24'h000010, 1, 1'b0);

        // unknown command
        start();
        pulse(8'h9F);
        chk("ign_state", st4, 6);
        wbuf[0] = 8'h00; wbuf[1] = 8'h00; wbuf[2] = 8'h10;
        wbuf[3] = 8'hAA; wbuf[4] = 8'hBB; wbuf[5] = 8'hCC;
        for (int i = 0; i < 6; i++) begin
            pulse(wbuf[i]);
            chk("ign_state_b", st4, 6);
            chk("ign_oe", oe4, 0);
            chk("ign_oe0", oe0, 0);
        end
        stop();
        rd_txn(24'h000010, 2, 1'b0);

        // LAT=0 instance
        rd_txn(24'h000010, 2, 1'b1);
        rd_txn(24'h000FFF, 2, 1'b1);

        // reset during an active read burst
        start();
        pulse(8'h0B);
        pulse(8'h00);
        pulse(8'h00);
        pulse(8'h10);
        for (int i = 0; i < 4; i++) pulse(8'h00);
        #40;
        chk("mid_oe", oe4, 1);
        chk("mid_dout", dout4, model[16'h010]);
        sclk = 1'b1;
        #40 sclk = 1'b0;
        #20 rst = 1'b1;
        #1;
        chk("arst_oe", oe4, 0);
        chk("arst_state", st4, 0);
        chk("arst_busy", busy4, 0);
        chk("arst_dout", dout4, 0);
        #19 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(8'h55);
            chk("post_rst_state", st4, 0);
            chk("post_rst_oe", oe4, 0);
            chk("post_rst_state0", st0, 0);
        end
        csn = 1'b1;
        #60;
        rd_txn(24'h000010, 2, 1'b0);

        // random bursts
        for (int it = 0; it < 8; it++) begin
            ra = 24'($urandom());
            rn = $urandom_range(1, 6);
            for (int i = 0; i < rn; i++) wbuf[i] = 8'($urandom());
            wr_txn(ra, rn);
            qa.push_back(ra);
            qn.push_back(rn);
            k = $urandom_range(0, qa.size() - 1);
            rd_txn(qa[k], qn[k], 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/psram_responder.md
# psram_responder

Octal-bus PSRAM responder that stands in for the external PSRAM chip during FPGA loopback and simulation. It samples the chip-select, serial clock and 8-bit data lines driven by the design's PSRAM controller, decodes command, address and data phases, and serves reads and writes from an internal byte-wide memory. The board top level maps its data output and output enable onto the `io_psram_data0..7` pads, or wires them back to the controller in loopback builds.

## Interface
Parameters:
- `ADDR_W`, 12: internal memory address width; depth is 2^ADDR_W bytes. Upper bus-address bits are ignored.
- `LAT`, 4: dummy `sclk` rising edges between the last address byte and the first read data byte. Range 0..15.

Ports:
- `i_clk`  in  1  system clock; must be at least 4x the `i_psram_sclk` frequency.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `i_psram_csn`  in  1  chip select, active low, asynchronous to `i_clk`.
- `i_psram_sclk`  in  1  bus serial clock, asynchronous to `i_clk`.
- `i_psram_din`  in  8  bus data from the initiator.
- `o_psram_dout`  out  8  bus data to the initiator.
- `o_psram_oe`  out  1  high while the responder drives the data bus.
- `o_state`  out  3  current FSM state encoding, for debug.
- `o_busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- `i_psram_csn`, `i_psram_sclk` and `i_psram_din` each pass through a 2-flop synchronizer. A third flop on `sclk` provides rising-edge (`rise`) and falling-edge (`fall`) detection. Data is taken from the synchronized `din` on the `rise` cycle.
- A transaction is one CSn-low window. Bytes are sampled on each `sclk` rising edge, most significant byte first.
- The byte-phase counter is 2 bits. The address register is 24 bits; only `[ADDR_W-1:0]` indexes memory.
- FSM states and encodings:
  - IDLE(0): entered on synchronized CSn falling edge, goes to CMD.
  - CMD(1): byte 0 is the command. 0x02 selects write, 0x0B selects read. Any other value goes to IGNORE.
  - ADDR(2): 3 bytes, addr[23:16], addr[15:8], addr[7:0].
  - DUMMY(3): counts LAT rises. With LAT=0 the FSM goes straight to RD_DATA.
  - RD_DATA(4):
    - On the first `fall` after entry, `o_psram_oe` goes to 1 and `o_psram_dout` becomes mem[addr].
    - On each later `fall`, addr increments and `o_psram_dout` becomes mem[addr].
  - WR_DATA(5): on each `rise`, mem[addr] is written with `din` and addr increments.
  - IGNORE(6): no action until CSn rises.
- Address increment wraps modulo 2^ADDR_W.
- Synchronized CSn high in any state:
  - The FSM returns to IDLE on the next `i_clk` cycle and `o_psram_oe` drops that same cycle.
  - A partial command or address is discarded; a partially written byte is never written.
  - This covers CSn rising mid-byte and mid-burst.
- If CSn rises in the same cycle as a `rise`, CSn wins and no write occurs.
- A write followed later by a read of the same address returns the written value. A read in the same transaction as a write is not possible, since the command is fixed per transaction.
- Reset values: `o_psram_dout`=0, `o_psram_oe`=0, `o_state`=0, `o_busy`=0, synchronizers=CSn high / sclk low. Memory contents are not reset.
- Reset asserted mid-transaction forces all of the above immediately. The responder then waits for a fresh CSn falling edge; a transaction already in flight is ignored until CSn goes high.

## Timing
- Input-to-internal latency is 2 `i_clk` cycles, plus 1 for edge detection.
- Read data is valid on `o_psram_dout` within 4 `i_clk` cycles of the pad `sclk` falling edge. This includes one registered memory read, with mem[addr+1] prefetched during the current byte.
- The initiator samples read data on the following `sclk` rising edge, which requires `sclk` high/low times of at least 2 `i_clk` periods each.
- The first read byte appears after edge count 1+3+LAT rises, on the next fall.
- A write commits to memory 1 `i_clk` cycle after the detected `rise`.
- `o_busy` rises 3 cycles after the pad CSn falls and falls 3 cycles after the pad CSn rises.

## Test plan
- **Reset:** assert `i_rst` during an active RD_DATA burst.
  - Required: `o_psram_oe`=0 and `o_state`=0 asynchronously.
  - Required: no bus activity until the next CSn falling edge.
- **Write/read round trip, ADDR_W=12, LAT=4:**
  - Stimulus: write 0x02, addr 0x000010, data A5 3C; then read 0x0B, addr 0x000010.
  - Required: after 4 dummy rises, `dout` returns A5 then 3C.
  - Required: `oe` is high only in RD_DATA.
- **Wrap-around:**
  - Stimulus: write bytes 11 22 at addr 0x000FFF; read from 0x000000.
  - Required: the read returns 22, and mem[0xFFF] reads back as 11.
  - Stimulus: a bus address of 0xABC010 after the same writes.
  - Required: it aliases to 0x010.
- **Abort:** raise CSn after 2 address bytes of a write, then read the target.
  - Required: the target is unchanged.
  - Required: FSM is IDLE 3 cycles after CSn rises.
- **Unknown command 0x9F:** followed by 6 clocked bytes.
  - Required: `o_state`=6, `oe` stays 0, memory unchanged.
- **LAT=0 read:**
  - Required: the first data byte is driven on the fall immediately after the addr[7:0] rise.
